// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle wide adder/subtractor. One 32-bit carry-select
// adder is time-shared across WORDS slices, least-significant slice first,
// with the inter-slice carry held in a register between cycles.

// csa_32b: 32-bit carry-select adder built from four 8-bit blocks. Each block
// forms both carry-in hypotheses, and the incoming block carry picks one.
module csa_32b (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] s_o,
  output logic        c_o
);

  logic [8:0] r0;
  logic [8:0] r1;
  logic       c;

  // Per-block dual sums, selected by the rippling block carry
  always_comb begin
    r0  = '0;
    r1  = '0;
    s_o = '0;
    c   = c_i;
    for (int unsigned g = 0; g < 4; g++) begin
      r0 = {1'b0, a_i[g*8 +: 8]} + {1'b0, b_i[g*8 +: 8]};
      r1 = {1'b0, a_i[g*8 +: 8]} + {1'b0, b_i[g*8 +: 8]} + 9'd1;
      s_o[g*8 +: 8] = c ? r1[7:0] : r0[7:0];
      c = c ? r1[8] : r0[8];
    end
    c_o = c;
  end

endmodule

module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  zero,
  output logic                  busy
);

  localparam int W  = 32 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   work_q;
  logic [W-1:0]   work_d;
  logic [W-1:0]   sum_q;
  logic [CW-1:0]  cnt_q;
  logic [CW+4:0]  off;
  logic           carry_q;
  logic           zacc_q;
  logic           zacc_d;
  logic           cout_q;
  logic           zero_q;
  logic [31:0]    sl_a;
  logic [31:0]    sl_b;
  logic [31:0]    sl_s;
  logic           sl_c;

  assign off = {cnt_q, 5'd0};

  // Pick the current slice of the latched operands
  always_comb begin
    sl_a = a_q[off +: 32];
    sl_b = b_q[off +: 32];
  end

  csa_32b u_csa (
    .a_i (sl_a),
    .b_i (sl_b),
    .c_i (carry_q),
    .s_o (sl_s),
    .c_o (sl_c)
  );

  // Working register and zero flag as they stand after this slice; the last
  // slice copies these straight into the result so no extra cycle is needed
  always_comb begin
    work_d = work_q;
    work_d[off +: 32] = sl_s;
    zacc_d = zacc_q & (sl_s == '0);
  end

  // Control FSM plus the slice datapath registers and the held result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            // subtraction is A + ~B + 1: invert B once here, force carry-in
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            zacc_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          work_q  <= work_d;
          carry_q <= sl_c;
          zacc_q  <= zacc_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q   <= work_d;
            cout_q  <= sl_c;
            zero_q  <= zacc_d;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

endmodule
